// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared definitions for the two-requester adder arbiter.
//   WIDTH_DEFAULT : default operand/result width
//   out_state_e   : output-register FSM state (StEmpty / StFull)
//   ID_BRANCH     : requester index of the branch-target port (req0)
//   ID_SAD        : requester index of the SAD-accumulate port (req1)
package adder_arb_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } out_state_e;

    localparam logic ID_BRANCH = 1'b0;
    localparam logic ID_SAD    = 1'b1;

endpackage

// File: rtl/adder_arbiter_adder.sv
// adder_arbiter_adder: plain modular adder, carry-out discarded.
//   a_i, b_i : operands
//   sum_o    : (a_i + b_i) mod 2^Width
module adder_arbiter_adder #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one adder; result held in a single output register.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req0_valid/a/b, ready   : branch-target requester (ID_BRANCH)
//   req1_valid/a/b, ready   : SAD-accumulate requester (ID_SAD)
//   out_valid/data/id       : registered sum and owning requester
//   out_ready               : consumer takes the result this cycle
// PRIO_MODE 0 = round-robin, 1 = fixed priority with req0 winning.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    input  logic             out_ready
);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_id_q, out_id_d;
    // Requester that wins the next tie in round-robin mode.
    logic             prio_q, prio_d;

    logic             can_accept;
    logic             gnt0, gnt1;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b, sum;

    // Drain and refill in the same cycle is allowed.
    assign can_accept = (state_q == StEmpty) || out_ready;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // Gating with rst_n keeps readies low during reset, since the state is already EMPTY.
        if (rst_n && can_accept) begin
            if (PRIO_MODE == 1) begin
                if (req0_valid) begin
                    gnt0 = 1'b1;
                end else if (req1_valid) begin
                    gnt1 = 1'b1;
                end
            end else begin
                if (req0_valid && req1_valid) begin
                    gnt0 = (prio_q == ID_BRANCH);
                    gnt1 = (prio_q == ID_SAD);
                end else if (req0_valid) begin
                    gnt0 = 1'b1;
                end else if (req1_valid) begin
                    gnt1 = 1'b1;
                end
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;

    assign op_a = gnt1 ? req1_a : req0_a;
    assign op_b = gnt1 ? req1_b : req0_b;

    adder_arbiter_adder #(
        .Width(WIDTH)
    ) u_adder (
        .a_i  (op_a),
        .b_i  (op_b),
        .sum_o(sum)
    );

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        prio_d     = prio_q;
        if (accept) begin
            state_d    = StFull;
            out_data_d = sum;
            out_id_d   = gnt1 ? ID_SAD : ID_BRANCH;
            prio_d     = gnt1 ? ID_BRANCH : ID_SAD;
        end else if ((state_q == StFull) && out_ready) begin
            // Data and id hold their last values after a drain.
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            out_data_q <= '0;
            out_id_q   <= ID_BRANCH;
            prio_q     <= ID_BRANCH;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            prio_q     <= prio_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: drives a round-robin instance (index 0) and a fixed-priority instance
// (index 1) with identical stimulus and compares both against a behavioural model.
module tb_adder_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         out_ready = 1'b0;

    logic [1:0]        rdy0, rdy1, ov, oid;
    logic [1:0][W-1:0] od;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model state per instance.
    bit           m_full[2];
    logic [W-1:0] m_data[2];
    bit           m_id[2];
    int           m_last[2];   // requester granted most recently
    // Readies observed during the last step.
    logic [1:0]   obs_rdy0, obs_rdy1;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(W), .PRIO_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(rdy0[0]),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(rdy1[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_id(oid[0]), .out_ready(out_ready)
    );

    adder_arbiter #(.WIDTH(W), .PRIO_MODE(1)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(rdy0[1]),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(rdy1[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_id(oid[1]), .out_ready(out_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_grant(input int m, input bit v0, input bit v1, input bit ordy);
        if (m_full[m] && !ordy) return -1;
        if (v0 && v1) return (m == 1) ? 0 : 1 - m_last[m];
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_full[m] = 0;
            m_data[m] = '0;
            m_id[m]   = 0;
            m_last[m] = 1;
        end
    endtask

    // Reset asserted at a negedge with both valids high; checks the immediate effect.
    task automatic do_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        out_ready  = 1'b1;
        rst_n      = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            check_eq("rst_out_valid", ov[m], 0);
            check_eq("rst_out_data", od[m], 0);
            check_eq("rst_out_id", oid[m], 0);
            check_eq("rst_ready0", rdy0[m], 0);
            check_eq("rst_ready1", rdy1[m], 0);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
    endtask

    // One cycle: drive at negedge, check readies and outputs, then advance the model.
    task automatic step(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input bit ordy);
        int g[2];
        logic [W:0] s;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        out_ready  = ordy;
        #1;
        obs_rdy0 = rdy0;
        obs_rdy1 = rdy1;
        for (int m = 0; m < 2; m++) begin
            g[m] = exp_grant(m, v0, v1, ordy);
            check_eq(m == 0 ? "rr_ready0" : "fx_ready0", rdy0[m], g[m] == 0);
            check_eq(m == 0 ? "rr_ready1" : "fx_ready1", rdy1[m], g[m] == 1);
            check_eq(m == 0 ? "rr_out_valid" : "fx_out_valid", ov[m], m_full[m]);
            check_eq(m == 0 ? "rr_out_data" : "fx_out_data", od[m], m_data[m]);
            check_eq(m == 0 ? "rr_out_id" : "fx_out_id", oid[m], m_id[m]);
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (g[m] >= 0) begin
                s = (g[m] == 0) ? ({1'b0, a0} + {1'b0, b0}) : ({1'b0, a1} + {1'b0, b1});
                m_full[m] = 1;
                m_data[m] = s[W-1:0];
                m_id[m]   = (g[m] == 1);
                m_last[m] = g[m];
            end else if (m_full[m] && ordy) begin
                m_full[m] = 0;
            end
        end
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] corner[4];
        corner[0] = '0;
        corner[1] = '1;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h0000_0001;

        do_reset();

        // Single branch request: accepted same cycle, sum visible one cycle later.
        step(1, 32'h0000_0100, 32'h0000_0040, 0, '0, '0, 1);
        check_eq("basic_ready0", obs_rdy0[0], 1);
        check_eq("basic_valid", ov[0], 1);
        check_eq("basic_data", od[0], 32'h0000_0140);
        check_eq("basic_id", oid[0], 0);

        // Both valid, round-robin alternates from req0; fixed always picks req0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, $urandom, $urandom, 1, $urandom, $urandom, 1);
            check_eq("alt_rr_ready0", obs_rdy0[0], (i % 2) == 0);
            check_eq("alt_rr_id", oid[0], i % 2);
            check_eq("fx_never_ready1", obs_rdy1[1], 0);
            check_eq("fx_id", oid[1], 0);
        end

        // Backpressure while FULL, then drain plus one new accept in the same cycle.
        held = od[0];
        for (int i = 0; i < 3; i++) begin
            step(1, $urandom, $urandom, 1, $urandom, $urandom, 0);
            check_eq("stall_ready0", obs_rdy0[0], 0);
            check_eq("stall_ready1", obs_rdy1[0], 0);
            check_eq("stall_data", od[0], held);
        end
        step(1, 32'h10, 32'h20, 1, 32'h30, 32'h40, 1);
        check_eq("refill_one_ready", 64'(obs_rdy0[0]) + 64'(obs_rdy1[0]), 1);
        check_eq("refill_valid", ov[0], 1);

        // Carry out is dropped.
        step(0, '0, '0, 1, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        check_eq("wrap_data", od[0], 0);
        check_eq("wrap_id", oid[0], 1);
        check_eq("wrap_fx_data", od[1], 0);

        // Reset while FULL discards the result; req0 wins the next tie.
        check_eq("pre_rst_full", ov[0], 1);
        do_reset();
        step(1, 32'h5, 32'h6, 1, 32'h7, 32'h8, 1);
        check_eq("post_rst_ready0", obs_rdy0[0], 1);
        check_eq("post_rst_data", od[0], 32'hB);

        // Random traffic with occasional corner operands.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] a0, b0, a1, b1;
            a0 = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            b0 = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            a1 = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            b1 = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            step($urandom_range(1), a0, b0, $urandom_range(1), a1, b1, $urandom_range(3) != 0);
            if (i == 200) begin
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: PRIO_MODE, 0, arbitration policy (0 = round-robin, 1 = fixed, requester 0 wins).
REQ-003 Clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid  input  1  branch-target requester has operands.
REQ-006 req0_a, req0_b  input  WIDTH each  requester-0 operands (PC+4, shifted offset).
REQ-007 req0_ready  output  1  requester-0 operands accepted this cycle.
REQ-008 req1_valid  input  1  SAD-accumulate requester has operands.
REQ-009 req1_a, req1_b  input  WIDTH each  requester-1 operands (running sum, abs difference).
REQ-010 req1_ready  output  1  requester-1 operands accepted this cycle.
REQ-011 out_valid  output  1  result register holds an undelivered result.
REQ-012 out_data  output  WIDTH  registered sum.
REQ-013 out_id  output  1  requester that owns out_data (0 or 1).
REQ-014 out_ready  input  1  consumer takes result this cycle.

Function
REQ-015 Transfer on a request port occurs in a cycle where valid and ready are both 1; transfer on output occurs where out_valid and out_ready are both 1.
REQ-016 Output register FSM has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 can_accept = EMPTY, or FULL with out_ready=1 (drain and refill in same cycle).
REQ-018 At most one of req0_ready/req1_ready is 1 per cycle; neither is 1 when can_accept=0.
REQ-019 Readies are combinational from valids, can_accept and the priority pointer; a ready is never 1 while its own valid is 0.
REQ-020 PRIO_MODE=1: grant req0 whenever req0_valid; else req1 if req1_valid.
REQ-021 PRIO_MODE=0: single-request cycle grants that requester; when both valid, grant the one not granted most recently (pointer), pointer updates only on an actual transfer.
REQ-022 On transfer, next cycle out_data = (a + b) mod 2^WIDTH of granted port, out_id = granted index, out_valid=1; latency exactly one cycle.
REQ-023 Carry-out is discarded; 0xFFFFFFFF + 0x00000001 yields 0x00000000 with no flag.
REQ-024 FULL with out_ready=1 and no transfer: next state EMPTY, out_data/out_id hold last values.
REQ-025 FULL with out_ready=0: out_valid, out_data, out_id stable; no request accepted.
REQ-026 EMPTY with out_ready=1: no effect.
REQ-027 Exactly one result produced per accepted request; none dropped or duplicated.

Reset
REQ-028 Rst_n low forces immediately: out_valid=0, out_data=0, out_id=0, pointer favours req0, state EMPTY.
REQ-029 Reset mid-operation discards any pending result; readies are 0 while Rst_n is low.
REQ-030 First edge after Rst_n deasserts behaves as EMPTY with normal arbitration.

Structure
REQ-031 Package adder_arb_pkg holds WIDTH default, FSM state encoding (EMPTY, FULL), requester ID constants (ID_BRANCH=0, ID_SAD=1).
REQ-032 Summation is done by one instance of the team's Adder module fed by a grant-selected operand mux; arbiter, FSM and result register live in adder_arbiter.

Verification
REQ-033 Reset then req0 only, a=0x00000100, b=0x00000040, out_ready=1 -> req0_ready=1 same cycle; next cycle out_valid=1, out_data=0x00000140, out_id=0.
REQ-034 PRIO_MODE=0, both valid continuously, out_ready=1 -> grants alternate 0,1,0,1 starting with 0; out_id follows each cycle.
REQ-035 PRIO_MODE=1, both valid continuously -> req1_ready never 1; all results out_id=0.
REQ-036 FULL, out_ready=0 for 3 cycles with both valid -> both readies 0, out_data stable; out_ready=1 -> drain and one new accept same cycle.
REQ-037 req1 a=0xFFFFFFFF, b=0x00000001 -> out_data=0x00000000, out_id=1.
REQ-038 Rst_n pulsed low while FULL -> out_valid=0, out_data=0 immediately; next grant after release goes to req0 when both valid.
